// File: rtl/m6809_operand16_fetch_if.sv
// -----------------------------------------------------------------------------
// m6809_operand16_fetch_if
//
// Purpose: bundles the request/response handshake of the 16-bit operand
// sequencer together with its 8-bit memory bus.
//
// Signals:
//   start, is_write, ea[15:0], wdata[15:0], abort : word request side
//   busy, done, operand[15:0]                     : word status/result side
//   mem_addr[15:0], mem_rd, mem_wr, mem_wdata[7:0]: byte bus driven to memory
//   mem_rdata[7:0], mem_ready                     : byte bus returned by memory
//
// Modports:
//   master : the sequencer (drives the memory bus, reports status)
//   slave  : its environment (requester plus memory)
// -----------------------------------------------------------------------------
interface m6809_operand16_fetch_if;
  logic        start;
  logic        is_write;
  logic [15:0] ea;
  logic [15:0] wdata;
  logic        abort;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic        busy;
  logic        done;
  logic [15:0] operand;

  modport master (
    input  start, is_write, ea, wdata, abort, mem_rdata, mem_ready,
    output mem_addr, mem_rd, mem_wr, mem_wdata, busy, done, operand
  );

  modport slave (
    output start, is_write, ea, wdata, abort, mem_rdata, mem_ready,
    input  mem_addr, mem_rd, mem_wr, mem_wdata, busy, done, operand
  );
endinterface

// File: rtl/m6809_operand16_fetch.sv
// -----------------------------------------------------------------------------
// m6809_operand16_fetch
//
// Purpose: turns one 16-bit operand request into two byte cycles on the 6809
// 8-bit memory bus, big-endian (high byte at EA, low byte at EA+1). Reads
// assemble the ALU B operand; writes split a 16-bit result into two stores.
//
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : m6809_operand16_fetch_if.master (request, status and memory bus)
//
// Sequence: IDLE -> HI -> LO -> DONE -> IDLE. Every output is a flop, so the
// values for a phase are loaded on the edge that enters that phase.
// -----------------------------------------------------------------------------
module m6809_operand16_fetch (
  input  logic                           clk,
  input  logic                           rst_n,
  m6809_operand16_fetch_if.master        bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e      state_q,     state_d;
  logic [15:0] ea_q,        ea_d;
  logic [15:0] wdata_q,     wdata_d;
  logic        is_write_q,  is_write_d;
  logic [15:0] mem_addr_q,  mem_addr_d;
  logic        mem_rd_q,    mem_rd_d;
  logic        mem_wr_q,    mem_wr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        busy_q,      busy_d;
  logic        done_q,      done_d;
  logic [15:0] operand_q,   operand_d;

  // Second byte address; the 16-bit add drops the carry so FFFF wraps to 0000.
  logic [15:0] ea_plus1_s;
  assign ea_plus1_s = ea_q + 16'h0001;

  // Next-state and next-output computation for the byte sequencer.
  always_comb begin
    state_d     = state_q;
    ea_d        = ea_q;
    wdata_d     = wdata_q;
    is_write_d  = is_write_q;
    mem_addr_d  = mem_addr_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    operand_d   = operand_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          // Latch the request and present the high-byte cycle right away so
          // the strobe is visible in the first HI cycle.
          state_d     = ST_HI;
          ea_d        = bus.ea;
          wdata_d     = bus.wdata;
          is_write_d  = bus.is_write;
          mem_addr_d  = bus.ea;
          mem_wdata_d = bus.wdata[15:8];
          mem_rd_d    = ~bus.is_write;
          mem_wr_d    = bus.is_write;
          busy_d      = 1'b1;
        end else begin
          state_d     = ST_IDLE;
        end
      end

      ST_HI: begin
        if (bus.abort) begin
          // Abort beats mem_ready: drop strobes, capture nothing.
          state_d = ST_IDLE;
        end else if (bus.mem_ready) begin
          if (!is_write_q) begin
            operand_d[15:8] = bus.mem_rdata;
          end else begin
            operand_d[15:8] = operand_q[15:8];
          end
          state_d     = ST_LO;
          mem_addr_d  = ea_plus1_s;
          mem_wdata_d = wdata_q[7:0];
          mem_rd_d    = ~is_write_q;
          mem_wr_d    = is_write_q;
          busy_d      = 1'b1;
        end else begin
          // Wait state: address, data and strobe held unchanged.
          state_d  = ST_HI;
          mem_rd_d = ~is_write_q;
          mem_wr_d = is_write_q;
          busy_d   = 1'b1;
        end
      end

      ST_LO: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (bus.mem_ready) begin
          if (!is_write_q) begin
            operand_d[7:0] = bus.mem_rdata;
          end else begin
            operand_d[7:0] = operand_q[7:0];
          end
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b1;
        end else begin
          state_d  = ST_LO;
          mem_rd_d = ~is_write_q;
          mem_wr_d = is_write_q;
          busy_d   = 1'b1;
        end
      end

      ST_DONE: begin
        // done pulse lasts exactly one cycle; abort has no effect here.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous reset to the idle values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ea_q        <= 16'h0000;
      wdata_q     <= 16'h0000;
      is_write_q  <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= 8'h00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      operand_q   <= 16'h0000;
    end else begin
      state_q     <= state_d;
      ea_q        <= ea_d;
      wdata_q     <= wdata_d;
      is_write_q  <= is_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      operand_q   <= operand_d;
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.operand   = operand_q;

endmodule
